// File: rtl/chan_select_dbnc_if.sv
// chan_select_dbnc_if
// Bundles the channel selector's data/control signals.
//   in_bus    NCH*WIDTH  switch banks, channel k at [k*WIDTH +: WIDTH]
//   pba       1          raw pushbutton (bouncy, asynchronous)
//   mode_auto 1          raw slide switch, 1 = auto-scan
//   res       WIDTH      registered selected channel data
//   sel       SELW       registered active channel index
// master: board/stimulus side, slave: selector side.
interface chan_select_dbnc_if #(
  parameter int WIDTH = 4,
  parameter int NCH   = 2
);
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH*WIDTH-1:0] in_bus;
  logic                 pba;
  logic                 mode_auto;
  logic [WIDTH-1:0]     res;
  logic [SELW-1:0]      sel;

  modport master (
    output in_bus, pba, mode_auto,
    input  res, sel
  );

  modport slave (
    input  in_bus, pba, mode_auto,
    output res, sel
  );
endinterface

// File: rtl/chan_select_dbnc.sv
// chan_select_dbnc
// N-channel registered input selector. The active channel is stepped by a
// debounced pushbutton, or by an auto-scan timer when mode_auto is set.
// Ports:
//   clk  system clock
//   rst  asynchronous reset, active-high
//   bus  chan_select_dbnc_if.slave (in_bus, pba, mode_auto -> res, sel)
module chan_select_dbnc #(
  parameter int WIDTH       = 4,
  parameter int NCH         = 2,
  parameter int DEB_CYCLES  = 500000,
  parameter int SCAN_CYCLES = 50000000,
  parameter int PBA_ACT_LO  = 1
) (
  input  logic              clk,
  input  logic              rst,
  chan_select_dbnc_if.slave bus
);
  localparam int SELW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DEB_W  = $clog2(DEB_CYCLES);
  localparam int SCAN_W = $clog2(SCAN_CYCLES);
  localparam logic PBA_IDLE = (PBA_ACT_LO != 0);

  logic              pba_m, pba_q;
  logic              mode_m, mode_s;
  logic              stable;
  logic [DEB_W-1:0]  deb_cnt;
  logic [SCAN_W-1:0] scan_cnt;
  logic [SELW-1:0]   sel_q;
  logic [WIDTH-1:0]  res_q;

  logic              pba_s;
  logic              deb_done;
  logic              press;
  logic              scan_wrap;
  logic              mode_chg;
  logic [SELW-1:0]   sel_step;

  // pressed = 1 regardless of the button's electrical polarity
  assign pba_s     = (PBA_ACT_LO != 0) ? ~pba_q : pba_q;
  assign deb_done  = (deb_cnt == DEB_W'(DEB_CYCLES - 1));
  // only the released->pressed acceptance steps the channel
  assign press     = (pba_s != stable) && deb_done && pba_s;
  assign scan_wrap = (scan_cnt == SCAN_W'(SCAN_CYCLES - 1));
  // true on the edge where mode_s itself takes a new value
  assign mode_chg  = (mode_m != mode_s);
  assign sel_step  = (sel_q == SELW'(NCH - 1)) ? '0 : sel_q + SELW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pba_m    <= PBA_IDLE;
      pba_q    <= PBA_IDLE;
      mode_m   <= 1'b0;
      mode_s   <= 1'b0;
      stable   <= 1'b0;
      deb_cnt  <= '0;
      scan_cnt <= '0;
      sel_q    <= '0;
      res_q    <= '0;
    end else begin
      pba_m  <= bus.pba;
      pba_q  <= pba_m;
      mode_m <= bus.mode_auto;
      mode_s <= mode_m;

      if (pba_s != stable) begin
        if (deb_done) begin
          stable  <= pba_s;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + DEB_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end

      // a mode transition restarts the scan timer and swallows any step
      if (mode_chg) begin
        scan_cnt <= '0;
      end else if (mode_s) begin
        if (press || scan_wrap) begin
          sel_q    <= sel_step;
          scan_cnt <= '0;
        end else begin
          scan_cnt <= scan_cnt + SCAN_W'(1);
        end
      end else begin
        scan_cnt <= '0;
        if (press) sel_q <= sel_step;
      end

      res_q <= bus.in_bus[int'(sel_q)*WIDTH +: WIDTH];
    end
  end

  assign bus.sel = sel_q;
  assign bus.res = res_q;
endmodule

// File: tb/tb_chan_select_dbnc.sv
module tb_chan_select_dbnc;
  logic clk = 1'b0;
  logic rst = 1'b1;

  chan_select_dbnc_if #(.WIDTH(4), .NCH(3)) bus ();

  chan_select_dbnc #(
    .WIDTH(4), .NCH(3), .DEB_CYCLES(4), .SCAN_CYCLES(8), .PBA_ACT_LO(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] in_bus;
    int          exp_sel;
    logic [3:0]  exp_res;
  } vec_t;

  vec_t       vecs[4];
  logic [3:0] exp_q[$];
  int         n_vec = 0;
  int         n_bad = 0;
  int         cur_sel;

  function automatic logic [3:0] chan(int s);
    logic [11:0] v;
    v = bus.in_bus;
    return v[s*4 +: 4];
  endfunction

  task automatic chk(string name, int got, int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // each waited negedge retires one scoreboard entry: res one edge after a sel check
  task automatic cyc(int n);
    logic [3:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("res", int'(bus.res), int'(e));
      end
    end
  endtask

  task automatic expect_sel(string name, int s, logic [3:0] r);
    chk(name, int'(bus.sel), s);
    exp_q.push_back(r);
  endtask

  task automatic expect_ch(string name, int s);
    expect_sel(name, s, chan(s));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{12'hA53, 1, 4'h5};
    vecs[1] = '{12'hA53, 2, 4'hA};
    vecs[2] = '{12'hA53, 0, 4'h3};
    vecs[3] = '{12'h96E, 1, 4'h6};

    // 1: reset
    bus.in_bus    = 12'hA53;
    bus.pba       = 1'b1;
    bus.mode_auto = 1'b0;
    rst           = 1'b1;
    cyc(3);
    chk("rst_sel", int'(bus.sel), 0);
    chk("rst_res", int'(bus.res), 0);
    rst = 1'b0;
    expect_sel("post_rst_sel", 0, 4'h3);
    cyc(1);
    cur_sel = 0;

    // 2: clean manual presses from the table
    foreach (vecs[k]) begin
      bus.in_bus = vecs[k].in_bus;
      bus.pba    = 1'b0;
      cyc(5);
      expect_ch("press_pre", cur_sel);
      cyc(1);
      expect_sel("press_step", vecs[k].exp_sel, vecs[k].exp_res);
      cyc(1);
      bus.pba = 1'b1;
      cyc(10);
      expect_sel("press_rel", vecs[k].exp_sel, vecs[k].exp_res);
      cyc(1);
      cur_sel = vecs[k].exp_sel;
    end

    // 3: bounce shorter than the debounce window is ignored
    bus.pba = 1'b0; cyc(3);
    bus.pba = 1'b1; cyc(1);
    bus.pba = 1'b0; cyc(2);
    bus.pba = 1'b1; cyc(12);
    expect_ch("bounce_nostep", 1);
    cyc(1);
    // long hold steps exactly once, release never steps
    bus.pba = 1'b0;
    cyc(5);
    expect_ch("hold_pre", 1);
    cyc(1);
    expect_ch("hold_step", 2);
    cyc(4);
    bus.pba = 1'b1;
    cyc(5);
    expect_ch("hold_held", 2);
    cyc(8);
    expect_ch("hold_release", 2);
    cyc(1);

    // 6: reset during debounce drops the pending step
    bus.pba = 1'b0;
    cyc(3);
    rst     = 1'b1;
    bus.pba = 1'b1;
    exp_q.delete();
    cyc(2);
    chk("mid_deb_rst_sel", int'(bus.sel), 0);
    chk("mid_deb_rst_res", int'(bus.res), 0);
    rst = 1'b0;
    expect_ch("mid_deb_post", 0);
    cyc(12);
    expect_ch("mid_deb_nostep", 0);
    cyc(1);

    // 4: auto-scan from reset
    rst = 1'b1;
    bus.mode_auto = 1'b1;
    exp_q.delete();
    cyc(2);
    rst = 1'b0;
    expect_ch("auto_start", 0);
    cyc(9);  expect_ch("auto_e9", 0);
    cyc(1);  expect_ch("auto_e10", 1);
    cyc(7);  expect_ch("auto_e17", 1);
    cyc(1);  expect_ch("auto_e18", 2);
    cyc(8);  expect_ch("auto_e26", 0);
    cyc(2);
    bus.pba = 1'b0;           // debounce completes on the e34 scan wrap
    cyc(5);  expect_ch("coinc_pre", 0);
    cyc(1);  expect_ch("coinc_once", 1);
    bus.pba = 1'b1;
    cyc(7);  expect_ch("coinc_e41", 1);
    cyc(1);  expect_ch("coinc_restart", 2);

    // 5: leave auto with scan_cnt=5, sel freezes
    cyc(5);
    bus.mode_auto = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(10);
      expect_ch("manual_frozen", 2);
    end
    bus.mode_auto = 1'b1;     // mode_s rises two edges later
    cyc(9);  expect_ch("reauto_pre", 2);
    cyc(1);  expect_ch("reauto_step", 0);
    cyc(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
